// File: rtl/wt_lcd_pkg.sv
// Shared constants, FSM encoding and digit selection for the LCD time-line sequencer.
package wt_lcd_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_NUL   = 8'h00;
    localparam int         TIME_CHARS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_FIN
    } seq_state_e;

    // Character index -> BCD nibble of {H10,H1,M10,M1,S10,S1}; separators return 0.
    function automatic logic [3:0] time_digit(input logic [23:0] t, input logic [2:0] idx);
        logic [3:0] d;
        case (idx)
            3'd0:    d = t[23:20];
            3'd1:    d = t[19:16];
            3'd3:    d = t[15:12];
            3'd4:    d = t[11:8];
            3'd6:    d = t[7:4];
            3'd7:    d = t[3:0];
            default: d = 4'h0;
        endcase
        return d;
    endfunction

    function automatic logic is_sep(input logic [2:0] idx);
        return (idx == 3'd2) || (idx == 3'd5);
    endfunction

endpackage

// File: rtl/wt_lcd_time_sequencer_bcd_ascii_dec.sv
// Combinational BCD digit to ASCII decoder; non-BCD nibbles decode to NUL.
import wt_lcd_pkg::*;

module bcd_ascii_dec (
    input  logic [3:0] bcd,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_NUL;
        if (bcd <= 4'h9) begin
            ascii = 8'h30 + {4'h0, bcd};
        end
    end

endmodule

// File: rtl/wt_lcd_time_sequencer.sv
// Streams a snapshotted HH:MM:SS as 8 ASCII chars with DDRAM addresses over valid/ready.
// Optional blinking separators are built when BLINK_COLON_EN is defined.
import wt_lcd_pkg::*;

module wt_lcd_time_sequencer #(
    parameter logic [7:0] BASE_ADDR  = 8'h40,
    parameter logic [7:0] COLON_CHAR = 8'h3A,
    parameter logic [7:0] BAD_CHAR   = 8'h20
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        START,
    input  logic [23:0] TIME_BCD,
    output logic        CHAR_VALID,
    input  logic        CHAR_READY,
    output logic [7:0]  CHAR_DATA,
    output logic [7:0]  CHAR_ADDR,
    output logic        BUSY,
    output logic        DONE
);

    seq_state_e  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] snap_q, snap_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef BLINK_COLON_EN
    logic        phase_q, phase_d;
`endif

    logic [2:0]  sel_idx;
    logic [7:0]  dec_ascii;
    logic [7:0]  sep_char;
    logic [7:0]  next_char;
    logic [7:0]  next_addr;

    // The character being built is always the one presented on the following cycle.
    assign sel_idx = (state_q == ST_LOAD) ? 3'd0 : idx_q + 3'd1;

    bcd_ascii_dec u_dec (
        .bcd   (time_digit(snap_q, sel_idx)),
        .ascii (dec_ascii)
    );

`ifdef BLINK_COLON_EN
    assign sep_char = phase_q ? ASCII_SPACE : COLON_CHAR;
`else
    assign sep_char = COLON_CHAR;
`endif

    assign next_char = is_sep(sel_idx)          ? sep_char :
                       (dec_ascii == ASCII_NUL) ? BAD_CHAR : dec_ascii;
    assign next_addr = BASE_ADDR + {5'b0, sel_idx};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BLINK_COLON_EN
        phase_d = phase_q ^ done_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_LOAD;
                    snap_d  = TIME_BCD;
                    busy_d  = 1'b1;
                    idx_d   = 3'd0;
                end
            end
            ST_LOAD: begin
                state_d = ST_SEND;
                idx_d   = 3'd0;
                valid_d = 1'b1;
                data_d  = next_char;
                addr_d  = next_addr;
            end
            ST_SEND: begin
                if (valid_q && CHAR_READY) begin
                    if (idx_q == 3'(TIME_CHARS - 1)) begin
                        state_d = ST_FIN;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        data_d = next_char;
                        addr_d = next_addr;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            snap_q  <= 24'h0;
            valid_q <= 1'b0;
            data_q  <= ASCII_NUL;
            addr_q  <= BASE_ADDR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BLINK_COLON_EN
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BLINK_COLON_EN
            phase_q <= phase_d;
`endif
        end
    end

    assign CHAR_VALID = valid_q;
    assign CHAR_DATA  = data_q;
    assign CHAR_ADDR  = addr_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_wt_lcd_time_sequencer.sv
// Drives two sequencers (line-2 base 8'h40 and wrapping base 8'hFE) with shared stimulus
// and compares every character, address and status flag against a reference model.
module tb_wt_lcd_time_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [23:0] time_bcd;
    logic        ready;
    logic        a_valid, b_valid, a_busy, b_busy, a_done, b_done;
    logic [7:0]  a_data, b_data, a_addr, b_addr;

    int checks   = 0;
    int failures = 0;
    int frames_done = 0;

    always #5 clk = ~clk;

    wt_lcd_time_sequencer #(.BASE_ADDR(8'h40)) dut_a (
        .CLK(clk), .RESETN(resetn), .START(start), .TIME_BCD(time_bcd),
        .CHAR_VALID(a_valid), .CHAR_READY(ready), .CHAR_DATA(a_data),
        .CHAR_ADDR(a_addr), .BUSY(a_busy), .DONE(a_done)
    );

    wt_lcd_time_sequencer #(.BASE_ADDR(8'hFE)) dut_b (
        .CLK(clk), .RESETN(resetn), .START(start), .TIME_BCD(time_bcd),
        .CHAR_VALID(b_valid), .CHAR_READY(ready), .CHAR_DATA(b_data),
        .CHAR_ADDR(b_addr), .BUSY(b_busy), .DONE(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Separator blink phase: frames completed since reset, modulo 2, only when enabled.
    function automatic bit blink_phase(input int frames);
`ifdef BLINK_COLON_EN
        return (frames % 2) == 1;
`else
        return (frames < 0);
`endif
    endfunction

    // Reference character: positions 2/5 are separators, others map to digits 0..5.
    function automatic logic [7:0] exp_char(input logic [23:0] t, input int i, input bit ph);
        int         n;
        logic [3:0] d;
        if (i == 2 || i == 5) return ph ? 8'h20 : 8'h3A;
        n = i - i / 3;
        d = 4'((t >> (4 * (5 - n))) & 24'hF);
        return (d <= 4'd9) ? 8'h30 + 8'(d) : 8'h20;
    endfunction

    task automatic chk_status(input string tag, input logic v, input logic b, input logic d);
        chk({tag, "_valid_a"}, a_valid, v);
        chk({tag, "_valid_b"}, b_valid, v);
        chk({tag, "_busy_a"},  a_busy,  b);
        chk({tag, "_busy_b"},  b_busy,  b);
        chk({tag, "_done_a"},  a_done,  d);
        chk({tag, "_done_b"},  b_done,  d);
    endtask

    // mode: 0 random ready, 1 ready always, 2 stall 3 cycles at idx 3,
    //       3 new time + START mid-frame and START in FIN, 4 reset at idx 4
    task automatic run_frame(input logic [23:0] bcd, input int mode);
        int k = 0;
        int stalls = 0;
        bit ph;
        logic [7:0] ec;
        ph = blink_phase(frames_done);
        @(negedge clk);
        time_bcd = bcd;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_status("load", 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        for (int cyc = 0; cyc < 100 && k < 8; cyc++) begin
            ec = exp_char(bcd, k, ph);
            chk_status("send", 1'b1, 1'b1, 1'b0);
            chk("data_a", a_data, ec);
            chk("data_b", b_data, ec);
            chk("addr_a", a_addr, 8'(32'h40 + k));
            chk("addr_b", b_addr, 8'(32'hFE + k));
            if (mode == 4 && k == 4) begin
                resetn = 1'b0;
                ready  = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
                frames_done = 0;
                chk_status("rst", 1'b0, 1'b0, 1'b0);
                chk("rst_data_a", a_data, 8'h00);
                chk("rst_addr_a", a_addr, 8'h40);
                chk("rst_addr_b", b_addr, 8'hFE);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk_status("post_rst", 1'b0, 1'b0, 1'b0);
                end
                return;
            end
            case (mode)
                1:       ready = 1'b1;
                2:       ready = !(k == 3 && stalls < 3);
                default: ready = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 2 && !ready) stalls++;
            start = (mode == 3 && k == 3 && start == 1'b0 && time_bcd == bcd);
            if (start) time_bcd = bcd ^ 24'h5A5A5A;
            @(negedge clk);
            start = 1'b0;
            if (ready) k++;
        end
        chk("frame_len", k, 8);
        chk_status("fin", 1'b0, 1'b0, 1'b1);
        frames_done++;
        if (mode == 2) chk("stall_cycles", stalls, 3);
        start = (mode == 3);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk_status("idle", 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [23:0] rb;
        resetn   = 1'b0;
        start    = 1'b0;
        ready    = 1'b0;
        time_bcd = 24'h0;
        repeat (3) @(negedge clk);
        chk_status("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_data_a", a_data, 8'h00);
        chk("reset_data_b", b_data, 8'h00);
        chk("reset_addr_a", a_addr, 8'h40);
        chk("reset_addr_b", b_addr, 8'hFE);
        resetn = 1'b1;

        run_frame(24'h123456, 1);
        run_frame(24'h123456, 2);
        run_frame(24'h0A5F59, 1);
        run_frame(24'h235959, 3);
        run_frame(24'h012345, 4);
        run_frame(24'h123456, 1);
        run_frame(24'h123456, 1);
        for (int f = 0; f < 8; f++) begin
            for (int n = 0; n < 6; n++) begin
                rb[4*n +: 4] = 4'($urandom_range(0, 11));
            end
            run_frame(rb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
